// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: initiator side of the data_mem port; sequences single read, single write
// and block-copy commands. Optional address range check: define DATA_MEM_CTRL_ADDR_CHECK_EN.
module data_mem_ctrl #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 4,
    parameter int MEM_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [ADDR_W-1:0] req_len,
    output logic              resp_done,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_datain,
    input  logic [DATA_W-1:0] mem_dataout
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD      = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR      = 3'd3,
        S_CP_RD   = 3'd4,
        S_CP_WAIT = 3'd5,
        S_CP_WR   = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    localparam logic [1:0] OP_RD = 2'b00;
    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] OP_CP = 2'b10;

    state_t            state_r, state_n_s;
    logic [ADDR_W-1:0] addr_r, len_r, idx_r, idx_n_s;
    logic [DATA_W-1:0] wdata_r, cbuf_r, resp_rdata_r;
    logic              req_ready_r, resp_done_r, resp_err_r;
    logic              err_r, err_n_s;
    logic              accept_s;
    logic              rd_s, wr_s, addr_bad_s;
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] datain_s;
    logic [ADDR_W:0]   idx_inc_s;

    assign accept_s  = req_valid && req_ready_r;
    assign idx_inc_s = {1'b0, idx_r} + {{ADDR_W{1'b0}}, 1'b1};

    // Memory-side access decode from the current state and latched command fields
    always_comb begin
        rd_s     = 1'b0;
        wr_s     = 1'b0;
        addr_s   = {ADDR_W{1'b0}};
        datain_s = {DATA_W{1'b0}};
        case (state_r)
            S_RD: begin
                rd_s   = 1'b1;
                addr_s = addr_r;
            end
            S_WR: begin
                wr_s     = 1'b1;
                addr_s   = addr_r;
                datain_s = wdata_r;
            end
            S_CP_RD: begin
                rd_s   = 1'b1;
                addr_s = addr_r + idx_r;
            end
            S_CP_WR: begin
                wr_s     = 1'b1;
                addr_s   = wdata_r[ADDR_W-1:0] + idx_r;
                datain_s = cbuf_r;
            end
            default: begin
                rd_s     = 1'b0;
                wr_s     = 1'b0;
                addr_s   = {ADDR_W{1'b0}};
                datain_s = {DATA_W{1'b0}};
            end
        endcase
    end

`ifdef DATA_MEM_CTRL_ADDR_CHECK_EN
    localparam logic [ADDR_W:0] DEPTH_L = MEM_DEPTH[ADDR_W:0];
    assign addr_bad_s = (rd_s || wr_s) && ({1'b0, addr_s} >= DEPTH_L);
`else
    assign addr_bad_s = 1'b0;
`endif

    // An out-of-range access is suppressed here; the FSM reports it via DONE
    assign mem_read_en  = rd_s && !addr_bad_s && !rst;
    assign mem_write_en = wr_s && !addr_bad_s && !rst;
    assign mem_addr     = rst ? {ADDR_W{1'b0}} : addr_s;
    assign mem_datain   = rst ? {DATA_W{1'b0}} : datain_s;

    assign req_ready  = req_ready_r;
    assign resp_done  = resp_done_r;
    assign resp_err   = resp_err_r;
    assign resp_rdata = resp_rdata_r;

    // Next-state, copy index and sticky error decode
    always_comb begin
        state_n_s = state_r;
        idx_n_s   = idx_r;
        err_n_s   = err_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    idx_n_s = {ADDR_W{1'b0}};
                    err_n_s = (req_op == 2'b11);
                    case (req_op)
                        OP_RD:   state_n_s = S_RD;
                        OP_WR:   state_n_s = S_WR;
                        OP_CP:   state_n_s = (req_len != {ADDR_W{1'b0}}) ? S_CP_RD : S_DONE;
                        default: state_n_s = S_DONE;
                    endcase
                end else begin
                    state_n_s = S_IDLE;
                end
            end
            S_RD: begin
                if (addr_bad_s) begin
                    state_n_s = S_DONE;
                    err_n_s   = 1'b1;
                end else begin
                    state_n_s = S_RD_WAIT;
                end
            end
            S_RD_WAIT: state_n_s = S_DONE;
            S_WR: begin
                if (addr_bad_s) begin
                    err_n_s = 1'b1;
                end else begin
                    err_n_s = err_r;
                end
                state_n_s = S_DONE;
            end
            S_CP_RD: begin
                if (addr_bad_s) begin
                    state_n_s = S_DONE;
                    err_n_s   = 1'b1;
                end else begin
                    state_n_s = S_CP_WAIT;
                end
            end
            S_CP_WAIT: state_n_s = S_CP_WR;
            S_CP_WR: begin
                if (addr_bad_s) begin
                    state_n_s = S_DONE;
                    err_n_s   = 1'b1;
                end else begin
                    idx_n_s   = idx_inc_s[ADDR_W-1:0];
                    state_n_s = (idx_inc_s < {1'b0, len_r}) ? S_CP_RD : S_DONE;
                end
            end
            S_DONE:  state_n_s = S_IDLE;
            default: state_n_s = S_IDLE;
        endcase
    end

    // State, command latches and registered response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_IDLE;
            addr_r       <= {ADDR_W{1'b0}};
            len_r        <= {ADDR_W{1'b0}};
            idx_r        <= {ADDR_W{1'b0}};
            wdata_r      <= {DATA_W{1'b0}};
            cbuf_r       <= {DATA_W{1'b0}};
            resp_rdata_r <= {DATA_W{1'b0}};
            err_r        <= 1'b0;
            req_ready_r  <= 1'b1;
            resp_done_r  <= 1'b0;
            resp_err_r   <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            idx_r       <= idx_n_s;
            err_r       <= err_n_s;
            req_ready_r <= (state_n_s == S_IDLE);
            resp_done_r <= (state_n_s == S_DONE);
            resp_err_r  <= (state_n_s == S_DONE) && err_n_s;
            if (accept_s) begin
                addr_r  <= req_addr;
                wdata_r <= req_wdata;
                len_r   <= req_len;
            end
            if (state_r == S_RD_WAIT) begin
                resp_rdata_r <= mem_dataout;
            end
            if (state_r == S_CP_WAIT) begin
                cbuf_r <= mem_dataout;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Testbench for data_mem_ctrl: behavioural data_mem plus a reference model feeding
// scoreboard queues of expected memory accesses and responses.
module tb_data_mem_ctrl;

    localparam int AW = 4;
    localparam int DW = 4;
`ifdef DATA_MEM_CTRL_ADDR_CHECK_EN
    localparam int DEPTH = 12;
`else
    localparam int DEPTH = 16;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'b00;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [AW-1:0] req_len = '0;
    logic          resp_done, resp_err;
    logic [DW-1:0] resp_rdata;
    logic          mem_read_en, mem_write_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_datain;
    logic [DW-1:0] mem_dataout = '0;

    logic [DW-1:0] ram    [0:15];
    logic [DW-1:0] shadow [0:15];
    logic [DW-1:0] last_rdata = '0;
    logic          both_seen = 1'b0;
    logic          rst_en_seen = 1'b0;
    int            tests_run = 0;
    int            tests_failed = 0;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } acc_t;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
        logic [7:0]    lat;
    } resp_t;

    acc_t  exp_acc  [$];
    resp_t exp_resp [$];

    data_mem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
        .resp_done(resp_done), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_dataout(mem_dataout)
    );

    always #5 clk = ~clk;

    // data_mem: registered read, dataout 0 when not reading, cleared by reset
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) ram[i] <= '0;
        end else if (mem_write_en) begin
            ram[mem_addr] <= mem_datain;
        end
        mem_dataout <= mem_read_en ? ram[mem_addr] : '0;
    end

    always @(negedge clk) begin
        if (mem_read_en && mem_write_en) both_seen <= 1'b1;
        if (rst && (mem_read_en || mem_write_en)) rst_en_seen <= 1'b1;
    end

    // Reference model: expected accesses and response for one command
    task automatic model_cmd(input logic [1:0] op, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [AW-1:0] len);
        resp_t r;
        acc_t  e;
        logic [AW-1:0] s, t, iv;
        logic [DW-1:0] v;
        r.rdata = last_rdata;
        r.err   = 1'b0;
        r.lat   = 8'd0;
        case (op)
            2'b00: begin
                if (int'(a) >= DEPTH) begin
                    r.err = 1'b1; r.lat = 8'd2;
                end else begin
                    e = '{we: 1'b0, addr: a, data: '0};
                    exp_acc.push_back(e);
                    r.rdata = shadow[a]; r.lat = 8'd3;
                end
            end
            2'b01: begin
                r.lat = 8'd2;
                if (int'(a) >= DEPTH) begin
                    r.err = 1'b1;
                end else begin
                    e = '{we: 1'b1, addr: a, data: d};
                    exp_acc.push_back(e);
                    shadow[a] = d;
                end
            end
            2'b10: begin
                r.lat = 8'(3 * int'(len) + 1);
                for (int i = 0; i < int'(len); i++) begin
                    iv = i[AW-1:0];
                    s  = a + iv;
                    t  = d[AW-1:0] + iv;
                    if (int'(s) >= DEPTH) begin
                        r.err = 1'b1; r.lat = 8'(3 * i + 2);
                        break;
                    end
                    e = '{we: 1'b0, addr: s, data: '0};
                    exp_acc.push_back(e);
                    v = shadow[s];
                    if (int'(t) >= DEPTH) begin
                        r.err = 1'b1; r.lat = 8'(3 * i + 4);
                        break;
                    end
                    e = '{we: 1'b1, addr: t, data: v};
                    exp_acc.push_back(e);
                    shadow[t] = v;
                end
            end
            default: begin
                r.err = 1'b1; r.lat = 8'd1;
            end
        endcase
        exp_resp.push_back(r);
        last_rdata = r.rdata;
    endtask

    // Drive one command, compare memory accesses and the response as the DUT produces them
    task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [AW-1:0] len,
                           input bit noise, output int first_en);
        resp_t r;
        acc_t  e;
        int    cyc;
        bit    seen;
        model_cmd(op, a, d, len);
        @(negedge clk);
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL accept_ready: got %b expected 1", req_ready);
        end
        req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = d; req_len = len;
        @(posedge clk);
        #1;
        if (noise) begin
            req_op = 2'b01; req_addr = 4'd3; req_wdata = 4'hf;
        end else begin
            req_valid = 1'b0;
        end
        cyc = 0; seen = 1'b0; first_en = -1;
        while (!seen && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (mem_read_en || mem_write_en) begin
                if (first_en < 0) first_en = cyc;
                tests_run++;
                if (exp_acc.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_access: we=%b addr=%0d expected none", mem_write_en, mem_addr);
                end else begin
                    e = exp_acc.pop_front();
                    if (mem_write_en !== e.we || mem_addr !== e.addr || (e.we && mem_datain !== e.data)) begin
                        tests_failed++;
                        $display("FAIL access: got we=%b addr=%0d data=%0d expected we=%b addr=%0d data=%0d",
                                 mem_write_en, mem_addr, mem_datain, e.we, e.addr, e.data);
                    end
                end
            end
            if (resp_done === 1'b1) seen = 1'b1;
        end
        req_valid = 1'b0;
        r = exp_resp.pop_front();
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL resp_timeout: no resp_done after %0d cycles, expected at %0d", cyc, r.lat);
        end else if (cyc != int'(r.lat) || resp_err !== r.err || resp_rdata !== r.rdata || req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL response: got lat=%0d err=%b rdata=%0d ready=%b expected lat=%0d err=%b rdata=%0d ready=0",
                     cyc, resp_err, resp_rdata, req_ready, r.lat, r.err, r.rdata);
        end
        tests_run++;
        if (exp_acc.size() != 0) begin
            tests_failed++;
            $display("FAIL missing_access: %0d expected accesses not issued, expected 0", exp_acc.size());
        end
        exp_acc.delete();
    endtask

    task automatic clear_model;
        for (int i = 0; i < 16; i++) shadow[i] = '0;
        last_rdata = '0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({req_ready, resp_done, resp_err, resp_rdata, mem_read_en, mem_write_en, mem_addr, mem_datain}
            !== {1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0}) begin
            tests_failed++;
            $display("FAIL reset_values: ready=%b done=%b err=%b rdata=%0d re=%b we=%b addr=%0d din=%0d expected 1,0,0,0,0,0,0,0",
                     req_ready, resp_done, resp_err, resp_rdata, mem_read_en, mem_write_en, mem_addr, mem_datain);
        end
        rst = 1'b0;
        clear_model();
    endtask

    task automatic test_read;
        int fe;
        for (int i = 1; i < 4; i++) run_cmd(2'b01, i[AW-1:0], 4'(i + 1), 4'd0, 1'b0, fe);
        run_cmd(2'b00, 4'd1, 4'd0, 4'd0, 1'b0, fe);
        tests_run++;
        if (fe != 1) begin
            tests_failed++;
            $display("FAIL read_en_timing: got cycle %0d expected 1", fe);
        end
    endtask

    task automatic test_write_read;
        int fe;
        run_cmd(2'b01, 4'd5, 4'd9, 4'd0, 1'b0, fe);
        tests_run++;
        if (fe != 1) begin
            tests_failed++;
            $display("FAIL write_en_timing: got cycle %0d expected 1", fe);
        end
        run_cmd(2'b00, 4'd5, 4'd0, 4'd0, 1'b0, fe);
        run_cmd(2'b00, 4'd0, 4'd0, 4'd0, 1'b0, fe);
    endtask

    task automatic test_copy;
        int fe;
        run_cmd(2'b10, 4'd1, 4'd8, 4'd3, 1'b0, fe);
        for (int i = 8; i < 11; i++) begin
            tests_run++;
            if (ram[i] !== shadow[i]) begin
                tests_failed++;
                $display("FAIL copy_ram[%0d]: got %0d expected %0d", i, ram[i], shadow[i]);
            end
        end
        run_cmd(2'b00, 4'd9, 4'd0, 4'd0, 1'b0, fe);
    endtask

    task automatic test_wrap;
        int fe;
        run_cmd(2'b01, 4'd14, 4'd7, 4'd0, 1'b0, fe);
        run_cmd(2'b01, 4'd15, 4'd6, 4'd0, 1'b0, fe);
        run_cmd(2'b10, 4'd14, 4'd0, 4'd3, 1'b0, fe);
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (ram[i] !== shadow[i]) begin
                tests_failed++;
                $display("FAIL wrap_ram[%0d]: got %0d expected %0d", i, ram[i], shadow[i]);
            end
        end
        run_cmd(2'b10, 4'd4, 4'd9, 4'd0, 1'b0, fe);
    endtask

    task automatic test_reserved;
        int fe;
        run_cmd(2'b11, 4'd2, 4'd2, 4'd2, 1'b0, fe);
        run_cmd(2'b00, 4'd2, 4'd0, 4'd0, 1'b0, fe);
    endtask

    task automatic test_back_to_back;
        int fe;
        run_cmd(2'b01, 4'd3, 4'd5, 4'd0, 1'b0, fe);
        run_cmd(2'b10, 4'd0, 4'd6, 4'd2, 1'b1, fe);
        run_cmd(2'b00, 4'd3, 4'd0, 4'd0, 1'b0, fe);
        run_cmd(2'b00, 4'd7, 4'd0, 4'd0, 1'b0, fe);
        @(negedge clk);
        tests_run++;
        if (resp_done !== 1'b0 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL done_pulse: done=%b ready=%b expected done=0 ready=1", resp_done, req_ready);
        end
    endtask

    task automatic test_reset_midcopy;
        int quiet;
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b10; req_addr = 4'd1; req_wdata = 4'd8; req_len = 4'd3;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++;
        if (mem_read_en !== 1'b0 || mem_write_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_gate: re=%b we=%b expected 0,0", mem_read_en, mem_write_en);
        end
        repeat (2) begin
            @(negedge clk);
            tests_run++;
            if ({req_ready, resp_done, resp_err, resp_rdata, mem_read_en, mem_write_en, mem_addr, mem_datain}
                !== {1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0}) begin
                tests_failed++;
                $display("FAIL midcopy_reset: ready=%b done=%b err=%b rdata=%0d re=%b we=%b addr=%0d din=%0d expected 1,0,0,0,0,0,0,0",
                         req_ready, resp_done, resp_err, resp_rdata, mem_read_en, mem_write_en, mem_addr, mem_datain);
            end
        end
        rst = 1'b0;
        clear_model();
        quiet = 0;
        repeat (12) begin
            @(negedge clk);
            if (resp_done !== 1'b0 || mem_read_en !== 1'b0 || mem_write_en !== 1'b0) quiet++;
        end
        tests_run++;
        if (quiet != 0 || rst_en_seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL dropped_cmd: activity cycles=%0d rst_enable=%b expected 0,0", quiet, rst_en_seen);
        end
    endtask

`ifdef DATA_MEM_CTRL_ADDR_CHECK_EN
    task automatic test_addr_check;
        int fe;
        run_cmd(2'b01, 4'd10, 4'd3, 4'd0, 1'b0, fe);
        run_cmd(2'b00, 4'd13, 4'd0, 4'd0, 1'b0, fe);
        run_cmd(2'b01, 4'd12, 4'd4, 4'd0, 1'b0, fe);
        run_cmd(2'b10, 4'd9, 4'd0, 4'd4, 1'b0, fe);
        run_cmd(2'b11, 4'd0, 4'd0, 4'd0, 1'b0, fe);
        tests_run++;
        if (ram[0] !== shadow[0] || ram[1] !== shadow[1]) begin
            tests_failed++;
            $display("FAIL partial_copy: got %0d,%0d expected %0d,%0d", ram[0], ram[1], shadow[0], shadow[1]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_write_read();
        test_copy();
        test_wrap();
        test_reserved();
        test_back_to_back();
        test_reset_midcopy();
`ifdef DATA_MEM_CTRL_ADDR_CHECK_EN
        test_addr_check();
`endif
        tests_run++;
        if (both_seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL exclusive_enables: both high seen=%b expected 0", both_seen);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
